timetag_byte_serializer: RTL

- Sits directly upstream of the FX2 bidirectional USB interface, on the fx2_clk domain.
- Buffers fixed-width timetag records from the acquisition logic and serializes them MSB-first into the byte stream offered to the FX2 interface (fpga_word / fpga_word_avail / fpga_word_accepted).
- Counts delivered bytes and answers the interface's request_length pulse with a 16-bit byte count for the current packet.

---
 rtl/timetag_byte_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/timetag_byte_serializer.sv
// Buffers fixed-width timetag records and serializes them MSB-first into the FX2 byte stream.
// Define TIMETAG_SERIALIZER_LOSS_CNT_EN to count records dropped on a full buffer.
module timetag_byte_serializer #(
  parameter int REC_BYTES = 6,
  parameter int DEPTH     = 4
) (
  input  logic                   fx2_clk,
  input  logic                   fx2_rst_n,
  input  logic [8*REC_BYTES-1:0] rec_data,
  input  logic                   rec_wr,
  output logic                   rec_full,
  input  logic                   capture_en,
  output logic [7:0]             fpga_word,
  output logic                   fpga_word_avail,
  input  logic                   fpga_word_accepted,
  input  logic                   request_length,
  output logic [15:0]            length,
  output logic [15:0]            lost_count
);

  localparam int RW   = 8 * REC_BYTES;
  localparam int AW   = $clog2(DEPTH);
  localparam int IW   = $clog2(REC_BYTES);
  localparam int LAST = REC_BYTES - 1;

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [IW-1:0] LAST_IDX = LAST[IW-1:0];
  localparam logic [IW-1:0] IDX_ONE  = 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  logic [RW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [IW-1:0] byte_idx;
  logic [15:0]   byte_cnt;
  logic [15:0]   len_q;
  logic [RW-1:0] head;
  logic [7:0]    head_byte;
  logic          wr_en;
  logic          acc;
  logic          last_byte;

  assign count           = wr_ptr - rd_ptr;
  assign rec_full        = (count == FULL_CNT);
  assign fpga_word_avail = (count != '0);
  assign wr_en           = rec_wr && capture_en && !rec_full;
  assign acc             = fpga_word_accepted && fpga_word_avail;
  assign last_byte       = (byte_idx == LAST_IDX);
  assign head            = mem[rd_ptr[AW-1:0]];
  assign length          = len_q;

  always_comb begin
    head_byte = 8'h00;
    for (int i = 0; i < REC_BYTES; i++) begin
      if (byte_idx == i[IW-1:0]) head_byte = head[RW-1-8*i -: 8];
    end
  end

  // Empty buffer must present 0x00 rather than whatever stale entry the read pointer lands on.
  assign fpga_word = fpga_word_avail ? head_byte : 8'h00;

  always_ff @(posedge fx2_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rec_data;
  end

  always_ff @(posedge fx2_clk or negedge fx2_rst_n) begin
    if (!fx2_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (acc) begin
        if (last_byte) begin
          byte_idx <= '0;
          rd_ptr   <= rd_ptr + PTR_ONE;
        end else begin
          byte_idx <= byte_idx + IDX_ONE;
        end
      end
      // A byte accepted alongside the snapshot pulse belongs to the closing packet.
      if (request_length) begin
        len_q    <= sat_inc(byte_cnt, acc);
        byte_cnt <= '0;
      end else begin
        byte_cnt <= sat_inc(byte_cnt, acc);
      end
    end
  end

`ifdef TIMETAG_SERIALIZER_LOSS_CNT_EN
  logic        drop;
  logic [15:0] lost_q;

  assign drop       = rec_wr && capture_en && rec_full;
  assign lost_count = lost_q;

  always_ff @(posedge fx2_clk or negedge fx2_rst_n) begin
    if (!fx2_rst_n) lost_q <= '0;
    else            lost_q <= sat_inc(lost_q, drop);
  end
`else
  assign lost_count = 16'h0000;
`endif

endmodule
